// File: rtl/wheel_meter_pkg.sv
// Shared definitions for the wheel-encoder meter: register offsets, status bit
// positions and the per-channel counter record.
package wheel_meter_pkg;

    localparam logic [1:0] REG_TOTAL  = 2'd0;
    localparam logic [1:0] REG_WINCNT = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int ST_WIN_VALID = 0;
    localparam int ST_PER_VALID = 1;
    localparam int ST_STALLED   = 2;
    localparam int ST_LEVEL     = 3;

    typedef struct packed {
        logic [31:0] total;
        logic [31:0] acc;
        logic [31:0] wincnt;
        logic        win_valid;
        logic        per_valid;
        logic        seen_edge;
    } ch_cnt_t;

endpackage

// File: rtl/wheel_evnt_meter_if.sv
// Register read/write port between the peripheral bus and the wheel meter.
interface wheel_evnt_meter_if;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output addr, rd, wr, wdata, input rdata, rvalid);
    modport slave  (input addr, rd, wr, wdata, output rdata, rvalid);
endinterface

// File: rtl/evnt_debounce.sv
// One encoder channel: 2-flop synchroniser, stability-count debounce and a
// registered rising-edge pulse of the filtered level.
module evnt_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk_sys,
    input  logic rst_sys,
    input  logic evnt,
    output logic level,
    output logic pulse
);
    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;
    logic             filt_prev_q;
    logic             pulse_q;

    // NOTE: all state uses <= so every flop samples pre-edge values; reset is synchronous.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], evnt};
            filt_prev_q <= filt_q;
            pulse_q     <= filt_q & ~filt_prev_q;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = filt_q;
    assign pulse = pulse_q;
endmodule

// File: rtl/wheel_evnt_meter.sv
// Wheel-encoder meter: per-channel edge total, windowed edge count and
// edge-to-edge period, exposed through a registered read/write port.
module wheel_evnt_meter
    import wheel_meter_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DEB_CYC = 16,
    parameter int WIN_CYC = 1000000,
    parameter int PER_W   = 24
) (
    input  logic                clk_sys,
    input  logic                rst_sys,
    input  logic [NCH-1:0]      evnt,
    wheel_evnt_meter_if.slave   bus,
    output logic [NCH-1:0]      evnt_pulse,
    output logic                win_irq
);
    localparam int WIN_W = $clog2(WIN_CYC);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [PER_W-1:0] PER_MAX  = '1;

    logic [WIN_W-1:0]  win_q;
    logic              win_irq_q;
    logic              win_tc;
    logic [NCH-1:0]    level;
    logic [3:0][31:0]  reg_words [NCH];
    logic [31:0]       rd_word;
    logic [31:0]       rdata_q;
    logic              rvalid_q;

    assign win_tc = (win_q == WIN_LAST);

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            win_q     <= '0;
            win_irq_q <= 1'b0;
        end else begin
            win_irq_q <= win_tc;
            win_q     <= win_tc ? '0 : win_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_cnt_t          cnt_q;
        logic [PER_W-1:0] run_q;
        logic [PER_W-1:0] per_q;
        logic             ch_sel;
        logic             wr_total;
        logic             w1c_win;
        logic             hit;
        logic             stalled;
        logic [3:0][31:0] words;

        evnt_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk_sys (clk_sys),
            .rst_sys (rst_sys),
            .evnt    (evnt[i]),
            .level   (level[i]),
            .pulse   (evnt_pulse[i])
        );

        assign ch_sel   = (bus.addr[3:2] == 2'(i));
        assign wr_total = bus.wr && ch_sel && (bus.addr[1:0] == REG_TOTAL);
        assign w1c_win  = bus.wr && ch_sel && (bus.addr[1:0] == REG_STATUS)
                          && bus.wdata[ST_WIN_VALID];
        assign hit      = evnt_pulse[i];
        assign stalled  = (run_q == PER_MAX);

        always_ff @(posedge clk_sys) begin
            if (rst_sys) begin
                cnt_q <= '0;
                run_q <= '0;
                per_q <= '0;
            end else begin
                // A clear that coincides with an edge keeps that edge.
                cnt_q.total <= wr_total ? {31'b0, hit} : cnt_q.total + {31'b0, hit};
                if (win_tc) begin
                    cnt_q.wincnt <= cnt_q.acc + {31'b0, hit};
                    cnt_q.acc    <= '0;
                end else begin
                    cnt_q.acc <= cnt_q.acc + {31'b0, hit};
                end
                cnt_q.win_valid <= win_tc | (cnt_q.win_valid & ~w1c_win);
                if (hit) begin
                    per_q           <= run_q;
                    run_q           <= PER_W'(1);
                    cnt_q.seen_edge <= 1'b1;
                    if (cnt_q.seen_edge) cnt_q.per_valid <= 1'b1;
                end else if (!stalled) begin
                    run_q <= run_q + 1'b1;
                end
            end
        end

        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            words                           = '0;
            words[REG_TOTAL]                = cnt_q.total;
            words[REG_WINCNT]               = cnt_q.wincnt;
            words[REG_PERIOD]               = 32'(per_q);
            words[REG_STATUS][ST_WIN_VALID] = cnt_q.win_valid;
            words[REG_STATUS][ST_PER_VALID] = cnt_q.per_valid;
            words[REG_STATUS][ST_STALLED]   = stalled;
            words[REG_STATUS][ST_LEVEL]     = level[i];
        end

        assign reg_words[i] = words;
    end

    // Channels at or above NCH fall through to the zero default.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.addr[3:2] == 2'(i)) rd_word = reg_words[i][bus.addr[1:0]];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= bus.rd;
            rdata_q  <= bus.rd ? rd_word : '0;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign win_irq    = win_irq_q;
endmodule

// File: tb/tb_wheel_evnt_meter.sv
// Directed bench for wheel_evnt_meter with DEB_CYC=4, WIN_CYC=100, PER_W=8;
// expected values are worked out by hand from the cycle timing of each step.
module tb_wheel_evnt_meter;
    import wheel_meter_pkg::*;

    localparam int NCH     = 2;
    localparam int DEB_CYC = 4;
    localparam int WIN_CYC = 100;
    localparam int PER_W   = 8;

    logic           clk_sys = 1'b0;
    logic           rst_sys = 1'b1;
    logic [NCH-1:0] evnt    = '0;
    logic [NCH-1:0] evnt_pulse;
    logic           win_irq;

    wheel_evnt_meter_if bus_if ();

    wheel_evnt_meter #(
        .NCH(NCH), .DEB_CYC(DEB_CYC), .WIN_CYC(WIN_CYC), .PER_W(PER_W)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_sys    (rst_sys),
        .evnt       (evnt),
        .bus        (bus_if),
        .evnt_pulse (evnt_pulse),
        .win_irq    (win_irq)
    );

    int n_checks       = 0;
    int n_errors       = 0;
    int cyc            = 0;
    int pulse_cnt      = 0;
    int pulse1_cnt     = 0;
    int last_pulse_cyc = -1;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        if (evnt_pulse[0] === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
        end
        if (evnt_pulse[1] === 1'b1) pulse1_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] addr_of(input int ch, input logic [1:0] r);
        logic [1:0] c;
        c = ch[1:0];
        return {c, r};
    endfunction

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        bus_if.addr = a;
        bus_if.rd   = 1'b1;
        tick();
        bus_if.rd   = 1'b0;
        check("rvalid_on_read", {31'b0, bus_if.rvalid}, 32'd1);
        d = bus_if.rdata;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] data);
        bus_if.addr  = a;
        bus_if.wdata = data;
        bus_if.wr    = 1'b1;
        tick();
        bus_if.wr    = 1'b0;
    endtask

    task automatic edge_ch0(input int hi, input int lo);
        evnt[0] = 1'b1;
        repeat (hi) tick();
        evnt[0] = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_win(input string tag);
        int n = 0;
        while (win_irq !== 1'b1 && n < 2 * WIN_CYC) begin
            tick();
            n++;
        end
        check(tag, {31'b0, win_irq}, 32'd1);
    endtask

    initial begin
        int          r_edge;
        int          k;
        logic [31:0] d;

        bus_if.addr  = '0;
        bus_if.rd    = 1'b0;
        bus_if.wr    = 1'b0;
        bus_if.wdata = '0;

        // Reset and idle behaviour.
        rst_sys = 1'b1;
        repeat (3) tick();
        r_edge  = cyc;
        rst_sys = 1'b0;
        check("rst_evnt_pulse", {30'b0, evnt_pulse}, 32'd0);
        check("rst_win_irq", {31'b0, win_irq}, 32'd0);
        check("rst_rvalid", {31'b0, bus_if.rvalid}, 32'd0);
        check("rst_rdata", bus_if.rdata, 32'd0);

        while (cyc < r_edge + WIN_CYC - 1) tick();
        check("win_irq_early", {31'b0, win_irq}, 32'd0);
        tick();
        check("win_irq_first", {31'b0, win_irq}, 32'd1);
        tick();
        check("win_irq_one_cycle", {31'b0, win_irq}, 32'd0);

        while (cyc < r_edge + 2 * WIN_CYC) tick();
        read_chk("idle_total", addr_of(0, REG_TOTAL), 32'd0);
        read_chk("idle_wincnt", addr_of(0, REG_WINCNT), 32'd0);
        read_chk("idle_period", addr_of(0, REG_PERIOD), 32'd0);
        read_chk("idle_status0", addr_of(0, REG_STATUS), 32'h1);
        read_chk("idle_status1", addr_of(1, REG_STATUS), 32'h1);
        read_chk("unmapped_ch2", addr_of(2, REG_TOTAL), 32'd0);
        tick();
        check("no_read_rvalid", {31'b0, bus_if.rvalid}, 32'd0);
        check("no_read_rdata", bus_if.rdata, 32'd0);
        check("idle_no_pulse", pulse_cnt, 32'd0);

        // Glitch shorter than DEB_CYC is rejected.
        edge_ch0(3, 15);
        check("glitch_no_pulse", pulse_cnt, 32'd0);
        read_chk("glitch_total", addr_of(0, REG_TOTAL), 32'd0);

        // Clean rising edge: one pulse, DEB_CYC+2 edges after first sampling.
        k = cyc + 1;
        edge_ch0(10, 20);
        check("held_pulse_count", pulse_cnt, 32'd1);
        check("held_pulse_cycle", last_pulse_cyc, k + DEB_CYC + 2);
        read_chk("held_total", addr_of(0, REG_TOTAL), 32'd1);
        do_read(addr_of(0, REG_STATUS), d);
        check("per_valid_after_1st", {31'b0, d[ST_PER_VALID]}, 32'd0);

        // Window-aligned 20-cycle edge train: 5 edges land in each window.
        wait_win("win_before_train");
        repeat (10) edge_ch0(10, 10);
        read_chk("train_period", addr_of(0, REG_PERIOD), 32'd20);
        read_chk("train_wincnt", addr_of(0, REG_WINCNT), 32'd5);
        read_chk("train_total", addr_of(0, REG_TOTAL), 32'd11);
        do_read(addr_of(0, REG_STATUS), d);
        check("train_per_valid", {31'b0, d[ST_PER_VALID]}, 32'd1);
        check("train_pulse_count", pulse_cnt, 32'd11);

        // Long gap saturates the period counter.
        repeat (300) tick();
        do_read(addr_of(0, REG_STATUS), d);
        check("stalled_status", {29'b0, d[3:1]}, 32'h3);
        evnt[0] = 1'b1;
        repeat (15) tick();
        read_chk("sat_period", addr_of(0, REG_PERIOD), 32'hFF);
        do_read(addr_of(0, REG_STATUS), d);
        check("unstalled_level_high", {30'b0, d[3:2]}, 32'h2);
        evnt[0] = 1'b0;
        repeat (15) tick();
        read_chk("sat_total", addr_of(0, REG_TOTAL), 32'd12);

        // Clear of TOTAL in the same cycle the edge is counted.
        evnt[0] = 1'b1;
        repeat (6) tick();
        check("pulse_not_yet", {31'b0, evnt_pulse[0]}, 32'd0);
        tick();
        check("pulse_now", {31'b0, evnt_pulse[0]}, 32'd1);
        do_write(addr_of(0, REG_TOTAL), 32'h0);
        read_chk("clear_with_edge_total", addr_of(0, REG_TOTAL), 32'd1);
        evnt[0] = 1'b0;
        repeat (15) tick();

        // Ignored writes: channel 3, and per_valid is not W1C.
        do_write(addr_of(3, REG_TOTAL), 32'h0);
        read_chk("ch3_write_ignored", addr_of(0, REG_TOTAL), 32'd1);
        do_write(addr_of(0, REG_STATUS), 32'h2);
        do_read(addr_of(0, REG_STATUS), d);
        check("per_valid_sticky", {31'b0, d[ST_PER_VALID]}, 32'd1);

        // W1C on the terminal-count edge loses to the set; alone it clears.
        while ((cyc - r_edge) % WIN_CYC != WIN_CYC - 1) tick();
        do_write(addr_of(0, REG_STATUS), 32'h1);
        check("w1c_align_win_irq", {31'b0, win_irq}, 32'd1);
        do_read(addr_of(0, REG_STATUS), d);
        check("w1c_set_wins", {31'b0, d[ST_WIN_VALID]}, 32'd1);
        do_write(addr_of(0, REG_STATUS), 32'h1);
        do_read(addr_of(0, REG_STATUS), d);
        check("w1c_clear", {31'b0, d[ST_WIN_VALID]}, 32'd0);

        // Read and write together: read sees the pre-write value.
        bus_if.addr  = addr_of(0, REG_TOTAL);
        bus_if.wdata = 32'h0;
        bus_if.rd    = 1'b1;
        bus_if.wr    = 1'b1;
        tick();
        bus_if.rd    = 1'b0;
        bus_if.wr    = 1'b0;
        check("rdwr_rvalid", {31'b0, bus_if.rvalid}, 32'd1);
        check("rdwr_pre_value", bus_if.rdata, 32'd1);
        read_chk("rdwr_cleared", addr_of(0, REG_TOTAL), 32'd0);

        // Build TOTAL=7, then reset mid-window.
        repeat (7) edge_ch0(8, 8);
        repeat (10) tick();
        read_chk("pre_reset_total", addr_of(0, REG_TOTAL), 32'd7);
        check("total_pulse_count", pulse_cnt, 32'd20);
        check("ch1_never_pulsed", pulse1_cnt, 32'd0);

        rst_sys = 1'b1;
        repeat (2) tick();
        r_edge  = cyc;
        rst_sys = 1'b0;
        check("rst2_win_irq", {31'b0, win_irq}, 32'd0);
        check("rst2_rvalid", {31'b0, bus_if.rvalid}, 32'd0);
        read_chk("rst2_total", addr_of(0, REG_TOTAL), 32'd0);
        read_chk("rst2_wincnt", addr_of(0, REG_WINCNT), 32'd0);
        read_chk("rst2_period", addr_of(0, REG_PERIOD), 32'd0);
        read_chk("rst2_status", addr_of(0, REG_STATUS), 32'd0);
        while (cyc < r_edge + WIN_CYC - 1) tick();
        check("rst2_win_irq_early", {31'b0, win_irq}, 32'd0);
        tick();
        check("rst2_win_irq_restart", {31'b0, win_irq}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
